bin_convm: RTL and testbench
============================

// Module: bin_convm
// PURPOSE
//  Decimal-to-binary converter, the inverse of bcd_convm. Accepts decimal digits
//  serially, most significant first, one digit per digit_pls. Accumulates
//  acc = acc*10 + digit with a two-cycle multiply/add sequence.
//  Presents the binary result on bin_out with a one-cycle done_pls.
//  Sits between a digit source (UART/ASCII parser or bcd_convm loopback) and binary consumers.
// PARAMETERS
//  BIN_W    27  result width; 27 bits covers 8 decimal digits (99999999)
//  DIGITS   8   digit count after which conversion completes automatically
//  ASCII_IN 1   1: digits are ASCII 0x30..0x39; 0: raw BCD 0x00..0x09
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  reset      in   1      asynchronous, active-high reset
//  start_pls  in   1      clear accumulator/count/errors, begin conversion
//  dec_in     in   8      digit code, sampled when digit_pls=1 and ready=1
//  digit_pls  in   1      one-cycle strobe: dec_in valid
//  end_pls    in   1      one-cycle strobe: terminate before DIGITS reached
//  ready      out  1      1 = converter accepts a digit this cycle
//  busy       out  1      1 = conversion in progress (not IDLE)
//  bin_out    out  BIN_W  converted value, held until next completion
//  done_pls   out  1      one-cycle strobe: bin_out updated
//  err_digit  out  1      sticky: a non-digit code was received
//  err_ovf    out  1      sticky: accumulator exceeded 2^BIN_W-1
// BEHAVIOUR
//  Reset: state=IDLE; acc, cnt, bin_out=0; ready, busy, done_pls, err_digit, err_ovf=0.
//  States: IDLE -> WAIT -> MUL -> ADD -> (WAIT | IDLE).
//  - IDLE: start_pls -> WAIT. Clear acc, cnt, end_pend, err_*. Set busy=1.
//    digit_pls and end_pls are ignored.
//  - WAIT (ready=1):
//    - Valid digit_pls: latch digit value (ASCII_IN ? dec_in-8'h30 : dec_in[3:0]), go to MUL.
//    - Invalid code (outside 0x30..0x39 / 0x00..0x09): set err_digit. Digit is discarded,
//      cnt is unchanged, stay in WAIT.
//    - end_pls without digit_pls: bin_out<=acc, done_pls=1 next cycle, go to IDLE.
//    - digit_pls and end_pls in the same cycle: process the valid digit, set end_pend,
//      finish after ADD.
//  - MUL (ready=0): prod <= (acc<<3)+(acc<<1), computed at BIN_W+4 bits. -> ADD.
//  - ADD (ready=0): sum = prod + digit.
//    - If sum > 2^BIN_W-1, set err_ovf. acc <= sum[BIN_W-1:0] (wraps). cnt++.
//    - If cnt+1==DIGITS or end_pend: bin_out<=sum[BIN_W-1:0], done_pls=1, go to IDLE.
//    - Otherwise go to WAIT.
//  - digit_pls/end_pls while ready=0 are dropped silently; the source spaces digits >=3 cycles.
//  - start_pls in any non-IDLE state restarts, exactly as from IDLE.
//    It has priority over digit_pls and end_pls; no done_pls is issued for the aborted run.
//  - Latency: digit_pls at cycle n -> acc valid at n+2, ready at n+3.
//    Last digit at n -> done_pls and new bin_out at n+2 (registered, visible n+3).
//  - busy=0 in IDLE, including the cycle done_pls is high.
//    err_* hold until next start_pls or reset.
//  - Reset mid-conversion: immediate return to the reset values above; bin_out is lost.
// TESTING
//  1. ASCII "91234567", digits 3 cycles apart -> bin_out=91234567 and done_pls 2 cycles
//     after the 8th digit_pls; err_digit=0, err_ovf=0.
//  2. "1","2", then end_pls -> bin_out=12, one done_pls, busy=0 afterwards.
//  3. "1", 0x41, "2", end_pls -> err_digit=1, bin_out=12.
//  4. DIGITS=9, "999999999" -> err_ovf=1, bin_out=60475903 (mod 2^27).
//  5. digit_pls 1 cycle after previous -> dropped. start_pls mid-run -> acc=0, no done_pls;
//     new "5", end_pls -> bin_out=5.
//  6. reset high during MUL -> state IDLE, bin_out=0, all flags 0.
//     start_pls then "7", end_pls -> bin_out=7.

Source files
------------

// File: rtl/bin_convm.sv
// bin_convm: serial decimal-to-binary converter.
// Digits arrive most significant first; each accepted digit runs a two-cycle
// multiply/add step (acc = acc*10 + digit). The result is presented on bin_out
// together with a one-cycle done_pls.
module bin_convm #(
  parameter int BIN_W    = 27,
  parameter int DIGITS   = 8,
  parameter bit ASCII_IN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_pls,
  input  logic [7:0]       dec_in,
  input  logic             digit_pls,
  input  logic             end_pls,
  output logic             ready,
  output logic             busy,
  output logic [BIN_W-1:0] bin_out,
  output logic             done_pls,
  output logic             err_digit,
  output logic             err_ovf
);

  localparam int CNT_W = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {IDLE, WAIT, MUL, ADD} state_t;

  state_t           state;
  logic [BIN_W-1:0] acc;
  logic [BIN_W+3:0] prod;
  logic [3:0]       digit;
  logic [CNT_W-1:0] cnt;
  logic             end_pend;

  logic             code_ok;
  logic [3:0]       code_val;
  logic [7:0]       code_off;
  logic [BIN_W+3:0] sum;
  logic             last_digit;

  // Decode the incoming code and form the add-stage sum and completion condition
  always_comb begin
    code_off   = dec_in - 8'h30;
    code_ok    = 1'b0;
    code_val   = 4'd0;
    if (ASCII_IN) begin
      code_ok  = (dec_in >= 8'h30) && (dec_in <= 8'h39);
      code_val = code_off[3:0];
    end else begin
      code_ok  = (dec_in <= 8'h09);
      code_val = dec_in[3:0];
    end
    sum        = prod + {{BIN_W{1'b0}}, digit};
    last_digit = end_pend || (cnt == CNT_W'(DIGITS - 1));
  end

  // Conversion FSM with registered status outputs; start_pls always restarts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      prod      <= '0;
      digit     <= 4'd0;
      cnt       <= '0;
      end_pend  <= 1'b0;
      bin_out   <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      done_pls  <= 1'b0;
      err_digit <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      done_pls <= 1'b0;
      if (start_pls) begin
        state     <= WAIT;
        acc       <= '0;
        cnt       <= '0;
        end_pend  <= 1'b0;
        err_digit <= 1'b0;
        err_ovf   <= 1'b0;
        busy      <= 1'b1;
        ready     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            ready <= 1'b0;
            busy  <= 1'b0;
          end
          WAIT: begin
            if (digit_pls && code_ok) begin
              digit    <= code_val;
              end_pend <= end_pls;
              state    <= MUL;
              ready    <= 1'b0;
            end else begin
              if (digit_pls) begin
                err_digit <= 1'b1;
              end
              if (end_pls) begin
                bin_out  <= acc;
                done_pls <= 1'b1;
                state    <= IDLE;
                busy     <= 1'b0;
                ready    <= 1'b0;
              end
            end
          end
          MUL: begin
            prod  <= {1'b0, acc, 3'b000} + {3'b000, acc, 1'b0};
            state <= ADD;
          end
          ADD: begin
            if (sum[BIN_W+3:BIN_W] != 4'd0) begin
              err_ovf <= 1'b1;
            end
            acc <= sum[BIN_W-1:0];
            cnt <= cnt + CNT_W'(1);
            if (last_digit) begin
              bin_out  <= sum[BIN_W-1:0];
              done_pls <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
              ready    <= 1'b0;
            end else begin
              state <= WAIT;
              ready <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bin_convm.sv
// tb_bin_convm: directed and randomized checks of bin_convm against a
// decimal-arithmetic reference model.
module tb_bin_convm;

  logic        clk;
  logic        reset;
  logic        start_pls;
  logic [7:0]  dec_in;
  logic        digit_pls;
  logic        end_pls;

  logic        ready, busy, done_pls, err_digit, err_ovf;
  logic [26:0] bin_out;
  logic        ready9, busy9, done_pls9, err_digit9, err_ovf9;
  logic [26:0] bin_out9;

  int checks = 0;
  int errors = 0;

  bin_convm #(.BIN_W(27), .DIGITS(8), .ASCII_IN(1'b1)) dut (
    .clk(clk), .reset(reset), .start_pls(start_pls), .dec_in(dec_in),
    .digit_pls(digit_pls), .end_pls(end_pls), .ready(ready), .busy(busy),
    .bin_out(bin_out), .done_pls(done_pls), .err_digit(err_digit), .err_ovf(err_ovf)
  );

  bin_convm #(.BIN_W(27), .DIGITS(9), .ASCII_IN(1'b1)) dut9 (
    .clk(clk), .reset(reset), .start_pls(start_pls), .dec_in(dec_in),
    .digit_pls(digit_pls), .end_pls(end_pls), .ready(ready9), .busy(busy9),
    .bin_out(bin_out9), .done_pls(done_pls9), .err_digit(err_digit9), .err_ovf(err_ovf9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_conv();
    start_pls = 1'b1;
    tick();
    start_pls = 1'b0;
  endtask

  // One-cycle digit strobe, optionally with end_pls in the same cycle
  task automatic send_digit(input logic [7:0] code, input logic with_end);
    dec_in    = code;
    digit_pls = 1'b1;
    end_pls   = with_end;
    tick();
    digit_pls = 1'b0;
    end_pls   = 1'b0;
  endtask

  // Digit followed by the two processing cycles, so the next digit is 3 cycles later
  task automatic digit_cycle(input logic [7:0] code);
    send_digit(code, 1'b0);
    tick();
    tick();
  endtask

  task automatic send_end();
    end_pls = 1'b1;
    tick();
    end_pls = 1'b0;
  endtask

  // Check a completion: done high now, busy low, value correct, done low next cycle
  task automatic check_done(input string tag, input logic [31:0] exp_val);
    check_output({tag, "_done"}, {31'd0, done_pls}, 32'd1);
    check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_output({tag, "_bin"}, {5'd0, bin_out}, exp_val);
    tick();
    check_output({tag, "_done_off"}, {31'd0, done_pls}, 32'd0);
  endtask

  // Reference: decimal accumulation in plain integer arithmetic
  longint ref_val;
  bit     ref_err;

  initial begin
    string       num;
    logic [7:0]  ch;
    int          len;
    int          d;
    logic [7:0]  bad;
    bit          with_end;

    reset     = 1'b1;
    start_pls = 1'b0;
    dec_in    = 8'h00;
    digit_pls = 1'b0;
    end_pls   = 1'b0;
    #12;
    tick();
    check_output("rst_bin", {5'd0, bin_out}, 32'd0);
    check_output("rst_ready", {31'd0, ready}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_done", {31'd0, done_pls}, 32'd0);
    check_output("rst_errs", {30'd0, err_digit, err_ovf}, 32'd0);
    reset = 1'b0;
    tick();

    // Eight ASCII digits complete automatically
    num = "91234567";
    start_conv();
    check_output("t1_busy", {31'd0, busy}, 32'd1);
    check_output("t1_ready", {31'd0, ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      ch = num[i];
      send_digit(ch, 1'b0);
      check_output("t1_ready_mul", {31'd0, ready}, 32'd0);
      tick();
      if (i < 7) begin
        check_output("t1_no_done", {31'd0, done_pls}, 32'd0);
        tick();
      end else begin
        check_output("t1_done_early", {31'd0, done_pls}, 32'd0);
        tick();
      end
    end
    check_output("t1_errs", {30'd0, err_digit, err_ovf}, 32'd0);
    check_done("t1", 32'd91234567);

    // Early termination with end_pls
    start_conv();
    digit_cycle("1");
    digit_cycle("2");
    send_end();
    check_done("t2", 32'd12);
    check_output("t2_busy_after", {31'd0, busy}, 32'd0);

    // Non-digit code is flagged and discarded
    start_conv();
    digit_cycle("1");
    send_digit(8'h41, 1'b0);
    check_output("t3_err_digit", {31'd0, err_digit}, 32'd1);
    check_output("t3_ready", {31'd0, ready}, 32'd1);
    digit_cycle("2");
    send_end();
    check_done("t3", 32'd12);
    check_output("t3_err_hold", {31'd0, err_digit}, 32'd1);

    // Nine nines overflow the 27-bit result on the 9-digit instance
    start_conv();
    check_output("t4_err_clear", {30'd0, err_digit, err_ovf}, 32'd0);
    for (int i = 0; i < 8; i++) digit_cycle("9");
    check_output("t4_d8_done", {31'd0, done_pls}, 32'd1);
    check_output("t4_d8_bin", {5'd0, bin_out}, 32'd99999999);
    check_output("t4_d9_busy", {31'd0, busy9}, 32'd1);
    digit_cycle("9");
    check_output("t4_d9_done", {31'd0, done_pls9}, 32'd1);
    check_output("t4_d9_bin", {5'd0, bin_out9}, 32'd60475903);
    check_output("t4_d9_ovf", {31'd0, err_ovf9}, 32'd1);
    check_output("t4_d8_ignored", {5'd0, bin_out}, 32'd99999999);
    tick();

    // Digits arriving while busy computing are dropped
    start_conv();
    send_digit("3", 1'b0);
    send_digit("4", 1'b0);
    send_digit("6", 1'b0);
    check_output("t5_ready_back", {31'd0, ready}, 32'd1);
    send_end();
    check_done("t5_drop", 32'd3);

    // Restart during MUL has priority, aborts without done
    start_conv();
    digit_cycle("8");
    send_digit("2", 1'b0);
    start_pls = 1'b1;
    digit_pls = 1'b1;
    dec_in    = "9";
    tick();
    start_pls = 1'b0;
    digit_pls = 1'b0;
    check_output("t5_restart_ready", {31'd0, ready}, 32'd1);
    check_output("t5_restart_done", {31'd0, done_pls}, 32'd0);
    tick();
    check_output("t5_restart_nodone", {31'd0, done_pls}, 32'd0);
    digit_cycle("5");
    send_end();
    check_done("t5_restart", 32'd5);

    // Reset during MUL returns everything to idle values
    start_conv();
    send_digit(8'h20, 1'b0);
    digit_cycle("6");
    send_digit("6", 1'b0);
    #2 reset = 1'b1;
    #2;
    check_output("t6_rst_bin", {5'd0, bin_out}, 32'd0);
    check_output("t6_rst_flags", {27'd0, ready, busy, done_pls, err_digit, err_ovf}, 32'd0);
    reset = 1'b0;
    tick();
    start_conv();
    digit_cycle("7");
    send_end();
    check_done("t6", 32'd7);

    // Randomized runs against the decimal reference
    for (int run = 0; run < 25; run++) begin
      len      = $urandom_range(1, 8);
      with_end = (len < 8) && ($urandom_range(0, 1) == 1);
      ref_val  = 0;
      ref_err  = 1'b0;
      start_conv();
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          bad = 8'($urandom_range(0, 255));
          if (bad >= 8'h30 && bad <= 8'h39) bad = 8'h3A;
          send_digit(bad, 1'b0);
          ref_err = 1'b1;
        end
        d       = $urandom_range(0, 9);
        ref_val = ref_val * 10 + d;
        ch      = 8'(8'h30 + d);
        if (i == len - 1 && with_end) begin
          send_digit(ch, 1'b1);
          tick();
          tick();
        end else begin
          digit_cycle(ch);
        end
      end
      if (len < 8 && !with_end) send_end();
      check_output("rnd_err_digit", {31'd0, err_digit}, {31'd0, ref_err});
      check_output("rnd_err_ovf", {31'd0, err_ovf}, 32'd0);
      check_done("rnd", 32'(ref_val % 134217728));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
